// File: rtl/prbs_sync_checker.sv
// prbs_sync_checker: self-synchronising PRBS receive checker with BER counters.
// Optional PRBS_CHK_AUTOINV_EN adds o_inverted and locks to 180-degree rotated streams.
module prbs_sync_checker #(
    parameter int ORDER     = 9,
    parameter int SYNC_BITS = 32,
    parameter int LOS_ERRS  = 16,
    parameter int LOS_WIN   = 128,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
`ifdef PRBS_CHK_AUTOINV_EN
    output logic             o_inverted,
`endif
    output logic             o_sat
);

    localparam int TAP = (ORDER == 7)  ? 6  :
                         (ORDER == 9)  ? 5  :
                         (ORDER == 15) ? 14 :
                         (ORDER == 23) ? 18 :
                         (ORDER == 31) ? 28 : 0;

    generate
        if (TAP == 0) begin : g_bad_order
            $error("prbs_sync_checker: unsupported ORDER %0d", ORDER);
        end
    endgenerate

    localparam int FILL_W  = $clog2(ORDER + 1);
    localparam int MATCH_W = $clog2(SYNC_BITS + 1);
    localparam int WIN_W   = $clog2(LOS_WIN + 1);
    localparam int WERR_W  = $clog2(LOS_ERRS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t             state, state_nx;
    logic [ORDER-1:0]   sreg, sreg_nx;
    logic [FILL_W-1:0]  fill, fill_nx;
    logic [MATCH_W-1:0] match, match_nx;
    logic [WIN_W-1:0]   win, win_nx;
    logic [WERR_W-1:0]  werr, werr_nx;
    logic               inv;
    logic               pred;
    logic               exp_bit;
    logic               err;
    logic               cnt_en;

`ifdef PRBS_CHK_AUTOINV_EN
    logic [MATCH_W-1:0] miss, miss_nx;
    logic               inv_nx;
    assign o_inverted = inv;
`else
    assign inv = 1'b0;
`endif

    // Expected bit is kept in the received polarity, so an inverted lock
    // regenerates the inverted sequence and compares i_bit directly.
    assign pred    = sreg[ORDER-1] ^ sreg[TAP-1];
    assign exp_bit = pred ^ inv;
    assign err     = i_bit ^ exp_bit;
    assign cnt_en  = i_valid && (state == LOCKED);
    assign o_locked = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
            sreg  <= '0;
            fill  <= '0;
            match <= '0;
            win   <= '0;
            werr  <= '0;
`ifdef PRBS_CHK_AUTOINV_EN
            miss  <= '0;
            inv   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            fill  <= fill_nx;
            match <= match_nx;
            win   <= win_nx;
            werr  <= werr_nx;
`ifdef PRBS_CHK_AUTOINV_EN
            miss  <= miss_nx;
            inv   <= inv_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        fill_nx  = fill;
        match_nx = match;
        win_nx   = win;
        werr_nx  = werr;
`ifdef PRBS_CHK_AUTOINV_EN
        miss_nx  = miss;
        inv_nx   = inv;
`endif
        if (i_valid) begin
            unique case (state)
                SEARCH: begin
                    sreg_nx = {sreg[ORDER-2:0], i_bit};
                    fill_nx = fill + 1'b1;
                    if (fill == FILL_W'(ORDER - 1)) begin
                        state_nx = VERIFY;
                        fill_nx  = '0;
                        match_nx = '0;
`ifdef PRBS_CHK_AUTOINV_EN
                        miss_nx  = '0;
`endif
                    end
                end
                VERIFY: begin
                    sreg_nx  = {sreg[ORDER-2:0], i_bit};
                    match_nx = err ? '0 : match + 1'b1;
`ifdef PRBS_CHK_AUTOINV_EN
                    miss_nx  = err ? miss + 1'b1 : '0;
`endif
                    if (!err && match == MATCH_W'(SYNC_BITS - 1)) begin
                        state_nx = LOCKED;
                        win_nx   = '0;
                        werr_nx  = '0;
                    end
`ifdef PRBS_CHK_AUTOINV_EN
                    else if (err && miss == MATCH_W'(SYNC_BITS - 1)) begin
                        state_nx = LOCKED;
                        inv_nx   = 1'b1;
                        win_nx   = '0;
                        werr_nx  = '0;
                    end
`endif
                end
                LOCKED: begin
                    sreg_nx = {sreg[ORDER-2:0], exp_bit};
                    if (err && werr == WERR_W'(LOS_ERRS - 1)) begin
                        state_nx = SEARCH;
                        fill_nx  = '0;
                        win_nx   = '0;
                        werr_nx  = '0;
`ifdef PRBS_CHK_AUTOINV_EN
                        inv_nx   = 1'b0;
`endif
                    end else if (win == WIN_W'(LOS_WIN - 1)) begin
                        win_nx  = '0;
                        werr_nx = '0;
                    end else begin
                        win_nx = win + 1'b1;
                        if (err) begin
                            werr_nx = werr + 1'b1;
                        end
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    // Clear takes priority over a bit counted on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
            o_sat     <= 1'b0;
        end else if (i_clear) begin
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
            o_sat     <= 1'b0;
        end else if (cnt_en) begin
            if (o_bit_cnt != CNT_MAX) begin
                o_bit_cnt <= o_bit_cnt + 1'b1;
            end
            if (err && o_err_cnt != CNT_MAX) begin
                o_err_cnt <= o_err_cnt + 1'b1;
            end
            if (o_bit_cnt == CNT_MAX - 1'b1) begin
                o_sat <= 1'b1;
            end
            if (err && o_err_cnt == CNT_MAX - 1'b1) begin
                o_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_sync_checker.sv
// tb_prbs_sync_checker: randomized PRBS9 stimulus against a queue-based reference model.
// Build with PRBS_CHK_AUTOINV_EN defined to exercise o_inverted.
module tb_prbs_sync_checker;

    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_bit = 1'b0;
    logic          i_clear = 1'b0;
    logic          o_locked;
    logic [CW-1:0] o_bit_cnt;
    logic [CW-1:0] o_err_cnt;
    logic          o_sat;
`ifdef PRBS_CHK_AUTOINV_EN
    logic          o_inverted;
`endif

    always #5 clk = ~clk;

    prbs_sync_checker #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_bit     (i_bit),
        .i_clear   (i_clear),
        .o_locked  (o_locked),
        .o_bit_cnt (o_bit_cnt),
        .o_err_cnt (o_err_cnt),
`ifdef PRBS_CHK_AUTOINV_EN
        .o_inverted(o_inverted),
`endif
        .o_sat     (o_sat)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: received history queue and event counters.
    bit m_hist[$];
    int m_mode;
    int m_fill, m_run, m_bad, m_k, m_werr;
    int m_bits, m_errs;
    bit m_sat, m_inv;

    task automatic model_reset();
        m_hist = {};
        repeat (9) m_hist.push_back(1'b0);
        m_mode = 0;
        m_fill = 0; m_run = 0; m_bad = 0; m_k = 0; m_werr = 0;
        m_bits = 0; m_errs = 0; m_sat = 0; m_inv = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit pred, e, er;
        int n;
        if (v) begin
            n = m_hist.size();
            pred = m_hist[n-9] ^ m_hist[n-5];
            case (m_mode)
                0: begin
                    m_hist.push_back(b);
                    m_fill++;
                    if (m_fill == 9) begin
                        m_mode = 1; m_fill = 0; m_run = 0; m_bad = 0;
                    end
                end
                1: begin
                    if (b == pred) begin m_run++; m_bad = 0; end
                    else begin m_bad++; m_run = 0; end
                    m_hist.push_back(b);
                    if (m_run == 32) begin
                        m_mode = 2; m_k = 0; m_werr = 0;
                    end
`ifdef PRBS_CHK_AUTOINV_EN
                    else if (m_bad == 32) begin
                        m_mode = 2; m_inv = 1; m_k = 0; m_werr = 0;
                    end
`endif
                end
                default: begin
                    e = pred ^ m_inv;
                    er = (b != e);
                    m_hist.push_back(e);
                    if (!clr) begin
                        if (m_bits < CMAX) m_bits++;
                        if (er && m_errs < CMAX) m_errs++;
                        if (m_bits == CMAX || m_errs == CMAX) m_sat = 1;
                    end
                    m_werr += int'(er);
                    if (m_werr == 16) begin
                        m_mode = 0; m_fill = 0; m_inv = 0;
                        m_k = 0; m_werr = 0;
                    end else begin
                        m_k++;
                        if (m_k == 128) begin m_k = 0; m_werr = 0; end
                    end
                end
            endcase
            if (m_hist.size() > 9) void'(m_hist.pop_front());
        end
        if (clr) begin m_bits = 0; m_errs = 0; m_sat = 0; end
    endtask

    logic [8:0] tx;
    int  nvalid, rise_at, fall_at;
    bit  prev_locked;

    task automatic observe();
        check("locked", o_locked, 64'(m_mode == 2));
        check("bit_cnt", o_bit_cnt, 64'(m_bits));
        check("err_cnt", o_err_cnt, 64'(m_errs));
        check("sat", o_sat, 64'(m_sat));
`ifdef PRBS_CHK_AUTOINV_EN
        check("inverted", o_inverted, 64'(m_inv));
`endif
        if (o_locked === 1'b1 && !prev_locked) rise_at = nvalid;
        if (o_locked === 1'b0 && prev_locked) fall_at = nvalid;
        prev_locked = (o_locked === 1'b1);
    endtask

    task automatic send(input bit v, input bit b, input bit clr);
        @(negedge clk);
        observe();
        i_valid = v;
        i_bit = b;
        i_clear = clr;
        model_step(v, b, clr);
        if (v) nvalid++;
    endtask

    task automatic idle();
        send(1'b0, 1'($urandom), 1'b0);
        @(negedge clk);
        observe();
    endtask

    task automatic next_tx(output bit b);
        b = tx[8] ^ tx[4];
        tx = {tx[7:0], b};
    endtask

    task automatic tx_send(input bit flip, input bit inv);
        bit b;
        next_tx(b);
        send(1'b1, b ^ flip ^ inv, 1'b0);
    endtask

    task automatic track_reset();
        model_reset();
        nvalid = 0; rise_at = -1; fall_at = -1; prev_locked = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
        @(negedge clk);
        check("rst_locked", o_locked, 0);
        check("rst_bit_cnt", o_bit_cnt, 0);
        check("rst_err_cnt", o_err_cnt, 0);
        check("rst_sat", o_sat, 0);
        rst = 1'b0;
        track_reset();
        tx = 9'h1AA;
    endtask

    bit flag[100];
    int last;

    initial begin
        // 1: clean stream locks on bit 41
        do_reset();
        repeat (100) tx_send(1'b0, 1'b0);
        idle();
        check("t1_lock_at", rise_at, 41);
        check("t1_bit_cnt", o_bit_cnt, 59);
        check("t1_err_cnt", o_err_cnt, 0);
        check("t1_sat", o_sat, 0);

        // 2: single line error counts once
        do_reset();
        repeat (60) tx_send(1'b0, 1'b0);
        tx_send(1'b1, 1'b0);
        repeat (80) tx_send(1'b0, 1'b0);
        idle();
        check("t2_err_cnt", o_err_cnt, 1);
        check("t2_locked", o_locked, 1);
        check("t2_no_fall", fall_at, -1);

        // 3: 16 errors in a window drop lock, then relock
        do_reset();
        repeat (41) tx_send(1'b0, 1'b0);
        foreach (flag[j]) flag[j] = 0;
        for (int c = 0; c < 16; ) begin
            int p;
            p = $urandom_range(0, 99);
            if (!flag[p]) begin flag[p] = 1; c++; end
        end
        last = 0;
        for (int j = 0; j < 100; j++) if (flag[j]) last = j;
        for (int j = 0; j < 100; j++) tx_send(flag[j], 1'b0);
        repeat (46) tx_send(1'b0, 1'b0);
        idle();
        check("t3_fall_at", fall_at, 41 + last + 1);
        check("t3_relock_at", rise_at, 41 + last + 1 + 41);
        check("t3_err_cnt", o_err_cnt, 16);

        // 4: sparse valid with garbage between
        do_reset();
        repeat (100) begin
            send(1'b0, 1'($urandom), 1'b0);
            send(1'b0, 1'($urandom), 1'b0);
            tx_send(1'b0, 1'b0);
        end
        idle();
        check("t4_lock_at", rise_at, 41);
        check("t4_bit_cnt", o_bit_cnt, 59);
        check("t4_err_cnt", o_err_cnt, 0);

        // 5: clear wins over counted bit; async reset mid-lock
        begin
            bit b;
            next_tx(b);
            send(1'b1, b, 1'b1);
        end
        idle();
        check("t5_clr_bit_cnt", o_bit_cnt, 0);
        check("t5_clr_err_cnt", o_err_cnt, 0);
        check("t5_clr_locked", o_locked, 1);
        repeat (10) tx_send(1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("t5_pre_bit_cnt", o_bit_cnt, 10);
        rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
        #1;
        check("t5_arst_locked", o_locked, 0);
        check("t5_arst_bit_cnt", o_bit_cnt, 0);
        check("t5_arst_err_cnt", o_err_cnt, 0);
        #1 rst = 1'b0;
        track_reset();
        idle();

        // 6: inverted stream
        do_reset();
        repeat (200) tx_send(1'b0, 1'b1);
        idle();
`ifdef PRBS_CHK_AUTOINV_EN
        check("t6_lock_at", rise_at, 41);
        check("t6_inverted", o_inverted, 1);
        check("t6_err_cnt", o_err_cnt, 0);
        check("t6_bit_cnt", o_bit_cnt, 159);
`else
        check("t6_never_lock", rise_at, -1);
        check("t6_locked", o_locked, 0);
`endif

        // 7: counter saturation and clear of sticky flag
        do_reset();
        repeat (41 + 260) tx_send(1'b0, 1'b0);
        idle();
        check("t7_bit_sat", o_bit_cnt, CMAX);
        check("t7_sat", o_sat, 1);
        send(1'b0, 1'b0, 1'b1);
        idle();
        check("t7_sat_clr", o_sat, 0);
        check("t7_bit_clr", o_bit_cnt, 0);

        // 8: random segments of error rate, polarity, valid gaps, clears
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            int rate;
            bit inv;
            case ($urandom_range(0, 2))
                0: rate = 0;
                1: rate = 50;
                default: rate = 6;
            endcase
            inv = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 200; c++) begin
                bit v, clr, fl;
                v = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 299) == 0);
                fl = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
                if (v) begin
                    bit b;
                    next_tx(b);
                    send(1'b1, b ^ fl ^ inv, clr);
                end else begin
                    send(1'b0, 1'($urandom), clr);
                end
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_sync_checker.md
Name: prbs_sync_checker

Overview:
- Self-synchronising PRBS receive checker, generalised in polynomial order, lock and loss-of-lock thresholds, and counter width.
- Sits after the QPSK demapper/slicer, one instance per I/Q rail.
- Locks to the received PRBS without knowing the transmitter seed, then free-runs a local copy.
- Counts compared bits and bit errors for BER measurement.

Parameters:
ORDER, 9, PRBS order; legal 7, 9, 15, 23, 31; any other value is a elaboration error.
SYNC_BITS, 32, consecutive correct predictions required to declare lock.
LOS_ERRS, 16, errors inside one window that force loss of lock.
LOS_WIN, 128, window length in compared bits for loss-of-lock detection.
CNT_W, 32, width of bit and error counters.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous reset, active-high.
i_valid  in  1  qualifies i_bit; one received bit per cycle when high.
i_bit  in  1  received hard-decision bit.
i_clear  in  1  synchronous clear of o_bit_cnt, o_err_cnt, o_sat.
o_locked  out  1  high while in LOCKED.
o_bit_cnt  out  CNT_W  bits compared while LOCKED.
o_err_cnt  out  CNT_W  mismatches while LOCKED.
o_sat  out  1  sticky; set when either counter saturates.

Behaviour:
- Reset: state SEARCH; shift register, fill, match and window counters all 0; o_locked=0, o_bit_cnt=0, o_err_cnt=0, o_sat=0.
- Shift register s[ORDER-1:0]: s[0] is the newest bit.
- Prediction p = s[ORDER-1] ^ s[T-1], where T = 6/5/14/18/28 for ORDER 7/9/15/23/31.
- Polynomials: x7+x6+1, x9+x5+1, x15+x14+1, x23+x18+1, x31+x28+1.
- All state changes occur only on cycles with i_valid=1. With i_valid=0 everything holds.
- SEARCH:
  - Shift i_bit into s; increment fill.
  - When fill reaches ORDER (ORDER-th valid bit), go to VERIFY with match=0.
- VERIFY:
  - Compare p against i_bit, then shift i_bit into s.
  - Match: match+1. Mismatch: match=0, stay in VERIFY.
  - When match reaches SYNC_BITS, go to LOCKED; o_locked=1 from the next cycle.
  - Clean stream: lock is declared on valid bit ORDER+SYNC_BITS (bit 41 for defaults).
- LOCKED:
  - Shift p, not i_bit, into s (local generation), so a single line error counts once.
  - o_bit_cnt +1 per valid bit; o_err_cnt +1 on each mismatch. Counters are registered, visible the cycle after the bit.
  - Window counter counts compared bits modulo LOS_WIN; window error counter counts mismatches.
  - At window end, window error count resets to 0.
  - When window errors reach LOS_ERRS: go to SEARCH, fill=0, window counters cleared, o_locked=0 the next cycle.
  - o_bit_cnt and o_err_cnt hold their values across loss of lock and relock; they do not reset.
- Counter saturation: counters stop at 2^CNT_W-1 and set o_sat.
- i_clear:
  - Zeroes o_bit_cnt, o_err_cnt, o_sat the next cycle.
  - Wins over a simultaneous counted bit; that bit is not counted.
  - Does not affect state, s, or window counters.
- rst asserted mid-operation: all outputs return to reset values immediately, with no clock edge required.

Optional Feature:
PRBS_CHK_AUTOINV_EN:
- When defined, resolves the QPSK 180-degree ambiguity and adds port o_inverted (out, 1), reset 0.
- VERIFY additionally counts consecutive mismatches. Reaching SYNC_BITS mismatches enters LOCKED with o_inverted=1.
- While o_inverted=1, i_bit is XOR-inverted before comparison.
- o_inverted is cleared on entry to SEARCH.
- When not defined, the port is absent and an inverted stream never locks.

Test Plan:
1. Reset, then 100 consecutive valid PRBS9 bits (bench LFSR seed 9'h1AA) -> o_locked rises the cycle after bit 41; at end o_bit_cnt=59, o_err_cnt=0, o_sat=0.
2. Lock as in 1, flip one bit 20 bits after lock, send 80 clean bits -> o_err_cnt=1 exactly, o_locked stays 1.
3. After lock, flip 16 bits within 100 compared bits -> o_locked falls the cycle after the 16th error, o_err_cnt=16; with clean bits following, relock occurs 41 valid bits after the loss.
4. Stimulus of 1 holding i_valid high only 1 cycle in 3, with i_bit driven to garbage on invalid cycles -> counts and lock point identical to 1 in valid-bit terms.
5. i_clear asserted on the same cycle as a counted bit (o_bit_cnt=59) -> next cycle o_bit_cnt=0, o_err_cnt=0, o_locked remains 1; async rst pulse mid-lock (between clock edges) -> o_locked=0 and both counters 0 before the next edge.
6. Inverted PRBS9 stream: with PRBS_CHK_AUTOINV_EN, o_locked and o_inverted both 1 after bit 41, o_err_cnt=0; without the macro, o_locked stays 0 for 200 bits.
